// File: rtl/alu_74382_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_74382_pkg
// Description : Shared definitions for the 74382-style ALU slice and its
//               serial, slice-at-a-time wrapper: select width, function
//               encodings, default widths and the sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_74382_pkg;

    localparam int SELECT_W       = 3;
    localparam int UINT_16_W      = 16;
    localparam int ORIG_OPERAND_W = 4;

    // Function select encodings (S2 S1 S0) of the 74382.
    localparam logic [SELECT_W-1:0] OP_CLEAR   = 3'd0;
    localparam logic [SELECT_W-1:0] OP_B_SUB_A = 3'd1;
    localparam logic [SELECT_W-1:0] OP_A_SUB_B = 3'd2;
    localparam logic [SELECT_W-1:0] OP_ADD     = 3'd3;
    localparam logic [SELECT_W-1:0] OP_XOR     = 3'd4;
    localparam logic [SELECT_W-1:0] OP_OR      = 3'd5;
    localparam logic [SELECT_W-1:0] OP_AND     = 3'd6;
    localparam logic [SELECT_W-1:0] OP_PRESET  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } t_seq_state;

    // True for the three functions that go through the internal adder.
    function automatic logic is_arith(input logic [SELECT_W-1:0] sel);
        return (sel == OP_B_SUB_A) || (sel == OP_A_SUB_B) || (sel == OP_ADD);
    endfunction

endpackage : alu_74382_pkg
`default_nettype wire

// File: rtl/alu_74382.sv
`default_nettype none
// ============================================================================
// Module      : alu_74382
// Description : Combinational model of one 74382 ALU slice.
//               Arithmetic functions form X + Y + Cn where X/Y are A/B with
//               the subtrahend inverted; logic functions ignore Cn.
// Ports       : i_sel  - function select
//               i_a    - operand A (W bits)
//               i_b    - operand B (W bits)
//               i_cn   - carry in (Cn)
//               o_f    - function result F
//               o_cn4  - carry out (Cn+4), 0 for non-arithmetic functions
//               o_ovr  - two's complement overflow, 0 for non-arithmetic
// Revision    : 1.0 - initial release
// ============================================================================
module alu_74382
    import alu_74382_pkg::*;
#(
    parameter int W = ORIG_OPERAND_W
) (
    input  logic [SELECT_W-1:0] i_sel,
    input  logic [W-1:0]        i_a,
    input  logic [W-1:0]        i_b,
    input  logic                i_cn,
    output logic [W-1:0]        o_f,
    output logic                o_cn4,
    output logic                o_ovr
);

    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic [W:0]   w_sum;
    logic         w_arith;
    logic         w_c_msb;

    // Operand conditioning: subtraction is addition of the one's complement,
    // so a borrow-free subtract needs Cn = 1.
    always_comb begin
        w_x = i_a;
        w_y = i_b;
        case (i_sel)
            OP_B_SUB_A: w_x = ~i_a;
            OP_A_SUB_B: w_y = ~i_b;
            default:    ;
        endcase
    end

    assign w_arith = is_arith(i_sel);
    assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, i_cn};

    // Carry into the sign bit, recovered from the sum bit and its operands.
    assign w_c_msb = w_x[W-1] ^ w_y[W-1] ^ w_sum[W-1];

    always_comb begin
        o_f = '0;
        case (i_sel)
            OP_CLEAR:   o_f = '0;
            OP_B_SUB_A: o_f = w_sum[W-1:0];
            OP_A_SUB_B: o_f = w_sum[W-1:0];
            OP_ADD:     o_f = w_sum[W-1:0];
            OP_XOR:     o_f = i_a ^ i_b;
            OP_OR:      o_f = i_a | i_b;
            OP_AND:     o_f = i_a & i_b;
            OP_PRESET:  o_f = '1;
            default:    o_f = '0;
        endcase
    end

    assign o_cn4 = w_arith & w_sum[W];
    assign o_ovr = w_arith & (w_c_msb ^ w_sum[W]);

endmodule : alu_74382
`default_nettype wire

// File: rtl/alu_74382_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_74382_seq
// Description : CHAIN_W-wide 74382 operation computed serially with a single
//               SLICE_W slice, least-significant slice first. The carry
//               register links consecutive slices exactly like a physical
//               Cn+4 -> Cn cascade. Fixed latency of NSLICE cycles from
//               acceptance to out_valid; result held until consumed.
// Ports       : clk, rst      - clock (rising edge), async active-high reset
//               in_valid/in_ready    - request handshake
//               in_sel, in_a, in_b   - function select and operands
//               in_carry             - carry into slice 0
//               out_valid/out_ready  - result handshake
//               out_result           - assembled F
//               out_overflow         - OVR of the last slice
//               out_carry            - Cn+4 of the last slice
// Options     : STICKY_OVF_EN adds ovf_clr (in) and ovf_sticky (out); the
//               sticky flag sets on every consumed overflowing result and is
//               cleared by ovf_clr, with set taking priority.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_74382_seq
    import alu_74382_pkg::*;
#(
    parameter int CHAIN_W = UINT_16_W,
    parameter int SLICE_W = ORIG_OPERAND_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SELECT_W-1:0] in_sel,
    input  logic [CHAIN_W-1:0]  in_a,
    input  logic [CHAIN_W-1:0]  in_b,
    input  logic                in_carry,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHAIN_W-1:0]  out_result,
    output logic                out_overflow,
    output logic                out_carry
`ifdef STICKY_OVF_EN
    ,
    input  logic                ovf_clr,
    output logic                ovf_sticky
`endif
);

    localparam int NSLICE = CHAIN_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

    if ((CHAIN_W % SLICE_W) != 0) begin : g_width_check
        $error("alu_74382_seq: CHAIN_W must be a multiple of SLICE_W");
    end

    t_seq_state            r_state;
    logic [SELECT_W-1:0]   r_sel;
    logic [CHAIN_W-1:0]    r_a;
    logic [CHAIN_W-1:0]    r_b;
    logic [CHAIN_W-1:0]    r_result;
    logic                  r_carry;
    logic                  r_ovf;
    logic [CNT_W-1:0]      r_cnt;

    logic [31:0]           w_base;
    logic [SLICE_W-1:0]    w_a_slice;
    logic [SLICE_W-1:0]    w_b_slice;
    logic [SLICE_W-1:0]    w_f;
    logic                  w_cn4;
    logic                  w_ovr;

    // Bit offset of the slice currently being processed.
    assign w_base    = 32'(r_cnt) * 32'(SLICE_W);
    assign w_a_slice = r_a[w_base +: SLICE_W];
    assign w_b_slice = r_b[w_base +: SLICE_W];

    alu_74382 #(
        .W      (SLICE_W)
    ) u_slice (
        .i_sel  (r_sel),
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cn   (r_carry),
        .o_f    (w_f),
        .o_cn4  (w_cn4),
        .o_ovr  (w_ovr)
    );

    // Sequencer. The carry register doubles as the inter-slice Cn and, once
    // the last slice is written, as the visible Cn+4; likewise the overflow
    // register keeps only the final slice's OVR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sel   <= in_sel;
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_carry;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[w_base +: SLICE_W] <= w_f;
                    r_carry <= w_cn4;
                    r_ovf   <= w_ovr;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE first keeps in_ready low in the
                    // consumption cycle.
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign out_result   = r_result;
    assign out_overflow = r_ovf;
    assign out_carry    = r_carry;

`ifdef STICKY_OVF_EN
    logic r_ovf_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if ((r_state == ST_DONE) && out_ready && r_ovf) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

endmodule : alu_74382_seq
`default_nettype wire
